// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// FSM controller for the multi-cycle 16-bit TSC CPU. Every instruction moves
// through IF/ID/EX/MEM/WB (skipping states it does not need). Fetches and data
// accesses wait on the memory's ready handshake. The unit also counts retired
// instructions and parks in HALT after HLT retires.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   instr           IR contents from the datapath (meaningful from ID onward)
//   mem_ready       memory finished the current read/write this cycle
//   br_taken        branch condition from the datapath (used in EX)
//   state           IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5
//   i_or_d          memory address select (0 = PC, 1 = ALU out)
//   mem_read/mem_write, ir_write, pc_write, pc_source
//   alu_src_a, alu_src_b, alu_op
//   rt_dest, reg_write, mem_to_reg, pc_to_reg, output_write
//   is_halted       sticky, set when HLT retires
//   illegal         one-cycle pulse in ID on an undefined instruction
//   num_inst        retired-instruction counter, wraps to zero
//
// All control outputs are combinational from the current state and instr,
// except the write handshakes in IF/MEM/EX which also look at mem_ready and
// br_taken.
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int WORD_SIZE      = 16,
  parameter int INST_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WORD_SIZE-1:0]      instr,
  input  logic                      mem_ready,
  input  logic                      br_taken,
  output logic [2:0]                state,
  output logic                      i_or_d,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic                      ir_write,
  output logic                      pc_write,
  output logic [1:0]                pc_source,
  output logic                      alu_src_a,
  output logic [1:0]                alu_src_b,
  output logic [2:0]                alu_op,
  output logic                      rt_dest,
  output logic                      reg_write,
  output logic                      mem_to_reg,
  output logic                      pc_to_reg,
  output logic                      output_write,
  output logic                      is_halted,
  output logic                      illegal,
  output logic [INST_CNT_WIDTH-1:0] num_inst
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  // Opcodes
  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_EXT = 4'd15;

  // Funcs under opcode 15 that are not plain ALU operations
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  // ALU function codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_SHL = 3'd6;

  localparam logic [INST_CNT_WIDTH-1:0] CNT_ONE = {{(INST_CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                    state_reg, state_next;
  logic [INST_CNT_WIDTH-1:0] num_inst_reg;
  logic                      is_halted_reg;
  logic                      retire;

  logic [3:0] opcode;
  logic [5:0] func;
  logic       unused_instr_bits;

  assign opcode            = instr[WORD_SIZE-1 -: 4];
  assign func              = instr[5:0];
  assign unused_instr_bits = ^instr[WORD_SIZE-5:6];

  // ---------------------------------------------------------------------------
  // Instruction classification
  // ---------------------------------------------------------------------------
  logic is_ext, is_rtype, is_itype, is_lwd, is_swd, is_branch;
  logic is_jmp, is_jal, is_jpr, is_jrl, is_wwd, is_hlt, is_legal;

  always_comb begin
    is_ext    = (opcode == OP_EXT);
    // ALU R-type ops occupy funcs 0..7
    is_rtype  = is_ext && (func[5:3] == 3'b000);
    is_itype  = (opcode == OP_ADI) || (opcode == OP_ORI) || (opcode == OP_LHI);
    is_lwd    = (opcode == OP_LWD);
    is_swd    = (opcode == OP_SWD);
    is_branch = (opcode >= OP_BNE) && (opcode <= OP_BLZ);
    is_jmp    = (opcode == OP_JMP);
    is_jal    = (opcode == OP_JAL);
    is_jpr    = is_ext && (func == FN_JPR);
    is_jrl    = is_ext && (func == FN_JRL);
    is_wwd    = is_ext && (func == FN_WWD);
    is_hlt    = is_ext && (func == FN_HLT);
    is_legal  = is_rtype || is_itype || is_lwd || is_swd || is_branch ||
                is_jmp || is_jal || is_jpr || is_jrl || is_wwd || is_hlt;
  end

  // ---------------------------------------------------------------------------
  // Next state and control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    retire       = 1'b0;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_source    = 2'd0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'd0;
    alu_op       = ALU_ADD;
    rt_dest      = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    pc_to_reg    = 1'b0;
    output_write = 1'b0;
    illegal      = 1'b0;

    unique case (state_reg)
      S_IF: begin
        // Read request stays up while the memory stalls; IR and PC+1 are
        // captured only in the cycle the data is actually returned.
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_ID;
        end
      end

      S_ID: begin
        if (!is_legal) begin
          // Undefined instruction: flag it and retire as a NOP.
          illegal = 1'b1;
          retire  = 1'b1;
        end else if (is_jmp || is_jal) begin
          pc_write  = 1'b1;
          pc_source = 2'd2;
          reg_write = is_jal;
          pc_to_reg = is_jal;
          retire    = 1'b1;
        end else if (is_jpr || is_jrl) begin
          pc_write  = 1'b1;
          pc_source = 2'd3;
          reg_write = is_jrl;
          pc_to_reg = is_jrl;
          retire    = 1'b1;
        end else if (is_wwd) begin
          output_write = 1'b1;
          retire       = 1'b1;
        end else if (is_hlt) begin
          retire = 1'b1;
        end else begin
          state_next = S_EX;
        end
      end

      S_EX: begin
        if (is_rtype) begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'd0;
          alu_op     = func[2:0];
          state_next = S_WB;
        end else if (is_itype) begin
          alu_src_b  = 2'd2;
          alu_op     = (opcode == OP_ADI) ? ALU_ADD :
                       (opcode == OP_ORI) ? ALU_ORR : ALU_SHL;
          state_next = S_WB;
        end else if (is_lwd || is_swd) begin
          alu_src_b  = 2'd2;
          alu_op     = ALU_ADD;
          state_next = S_MEM;
        end else begin
          // Branches: condition comes from the datapath comparator.
          alu_op    = ALU_SUB;
          pc_write  = br_taken;
          pc_source = 2'd1;
          retire    = 1'b1;
        end
      end

      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = is_lwd;
        mem_write = is_swd;
        if (mem_ready) begin
          if (is_lwd) state_next = S_WB;
          else        retire     = 1'b1;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        rt_dest    = is_itype || is_lwd;
        mem_to_reg = is_lwd;
        retire     = 1'b1;
      end

      S_HALT: begin
        state_next = S_HALT;
      end

      default: begin
        state_next = S_IF;
      end
    endcase

    if (retire) begin
      state_next = (state_reg == S_ID && is_hlt) ? S_HALT : S_IF;
    end
  end

  // ---------------------------------------------------------------------------
  // State, counter and halt flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IF;
      num_inst_reg  <= '0;
      is_halted_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (retire) begin
        num_inst_reg <= num_inst_reg + CNT_ONE;
      end
      if (state_reg == S_ID && is_hlt) begin
        is_halted_reg <= 1'b1;
      end
    end
  end

  assign state     = state_reg;
  assign num_inst  = num_inst_reg;
  assign is_halted = is_halted_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Directed bench for multicycle_control_unit. Each cycle of each instruction is
// checked against a hand-computed control vector and state. A second instance
// with an 8-bit counter shares the stimulus so counter wrap can be reached in a
// few hundred cycles.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        mem_ready;
  logic        br_taken;

  // Main instance (default widths)
  logic [2:0]  state;
  logic        i_or_d, mem_read, mem_write, ir_write, pc_write;
  logic [1:0]  pc_source;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic        rt_dest, reg_write, mem_to_reg, pc_to_reg, output_write;
  logic        is_halted, illegal;
  logic [15:0] num_inst;

  // Narrow-counter instance
  logic [2:0]  n_state;
  logic        n_i_or_d, n_mem_read, n_mem_write, n_ir_write, n_pc_write;
  logic [1:0]  n_pc_source;
  logic        n_alu_src_a;
  logic [1:0]  n_alu_src_b;
  logic [2:0]  n_alu_op;
  logic        n_rt_dest, n_reg_write, n_mem_to_reg, n_pc_to_reg, n_output_write;
  logic        n_is_halted, n_illegal;
  logic [7:0]  n_num_inst;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.WORD_SIZE(16), .INST_CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .br_taken(br_taken), .state(state), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .rt_dest(rt_dest), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg),
    .output_write(output_write), .is_halted(is_halted), .illegal(illegal),
    .num_inst(num_inst)
  );

  multicycle_control_unit #(.WORD_SIZE(16), .INST_CNT_WIDTH(8)) dut_n (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .br_taken(br_taken), .state(n_state), .i_or_d(n_i_or_d),
    .mem_read(n_mem_read), .mem_write(n_mem_write), .ir_write(n_ir_write),
    .pc_write(n_pc_write), .pc_source(n_pc_source), .alu_src_a(n_alu_src_a),
    .alu_src_b(n_alu_src_b), .alu_op(n_alu_op), .rt_dest(n_rt_dest),
    .reg_write(n_reg_write), .mem_to_reg(n_mem_to_reg),
    .pc_to_reg(n_pc_to_reg), .output_write(n_output_write),
    .is_halted(n_is_halted), .illegal(n_illegal), .num_inst(n_num_inst)
  );

  // Packed view of every control output, MSB first:
  // i_or_d mem_read mem_write ir_write pc_write pc_source[1:0] alu_src_a
  // alu_src_b[1:0] alu_op[2:0] rt_dest reg_write mem_to_reg pc_to_reg
  // output_write illegal
  logic [18:0] ctl_w;
  assign ctl_w = {i_or_d, mem_read, mem_write, ir_write, pc_write, pc_source,
                  alu_src_a, alu_src_b, alu_op, rt_dest, reg_write, mem_to_reg,
                  pc_to_reg, output_write, illegal};

  function automatic logic [18:0] c(
    input logic iod, input logic mr, input logic mw, input logic irw,
    input logic pcw, input logic [1:0] pcs, input logic asa,
    input logic [1:0] asb, input logic [2:0] aop, input logic rtd,
    input logic rw, input logic m2r, input logic p2r, input logic ow,
    input logic ill);
    return {iod, mr, mw, irw, pcw, pcs, asa, asb, aop, rtd, rw, m2r, p2r, ow, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check state and control vector for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input int st, input logic [18:0] ctl);
    #1;
    check({tag, " state"}, 32'(state), st);
    check({tag, " ctl"}, 32'(ctl_w), 32'(ctl));
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input string name);
    $display("txn %-8s instr=%04h state=%0d num_inst=%0d n_num_inst=%0d halted=%0b",
             name, instr, state, num_inst, n_num_inst, is_halted);
  endtask

  logic [18:0] IF_WAIT, IF_DONE, NONE;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    IF_WAIT = c(0,1,0,0,0,2'd0,0,2'd0,3'd0,0,0,0,0,0,0);
    IF_DONE = c(0,1,0,1,1,2'd0,0,2'd0,3'd0,0,0,0,0,0,0);
    NONE    = '0;

    reset = 1'b1; instr = 16'h0000; mem_ready = 1'b0; br_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("reset state", 32'(state), 0);
    check("reset num_inst", 32'(num_inst), 0);
    check("reset is_halted", 32'(is_halted), 0);
    check("reset ctl", 32'(ctl_w), 32'(IF_WAIT));

    // ADD $3,$0,$1
    instr = 16'hF1C0; mem_ready = 1'b1;
    cyc("add IF", 0, IF_DONE);
    cyc("add ID", 1, NONE);
    cyc("add EX", 2, c(0,0,0,0,0,2'd0,1,2'd0,3'd0,0,0,0,0,0,0));
    cyc("add WB", 4, c(0,0,0,0,0,2'd0,0,2'd0,3'd0,0,1,0,0,0,0));
    check("add num_inst", 32'(num_inst), 1);
    txn("ADD");

    // LWD $1,4($0) with 3 fetch stalls and 2 memory stalls
    instr = 16'h7104; mem_ready = 1'b0;
    repeat (3) cyc("lwd IF wait", 0, IF_WAIT);
    mem_ready = 1'b1;
    cyc("lwd IF", 0, IF_DONE);
    cyc("lwd ID", 1, NONE);
    cyc("lwd EX", 2, c(0,0,0,0,0,2'd0,0,2'd2,3'd0,0,0,0,0,0,0));
    mem_ready = 1'b0;
    repeat (2) cyc("lwd MEM wait", 3, c(1,1,0,0,0,2'd0,0,2'd0,3'd0,0,0,0,0,0,0));
    mem_ready = 1'b1;
    cyc("lwd MEM", 3, c(1,1,0,0,0,2'd0,0,2'd0,3'd0,0,0,0,0,0,0));
    cyc("lwd WB", 4, c(0,0,0,0,0,2'd0,0,2'd0,3'd0,1,1,1,0,0,0));
    check("lwd num_inst", 32'(num_inst), 2);
    check("lwd back to IF", 32'(state), 0);
    txn("LWD");

    // BEQ taken, then not taken
    instr = 16'h1002; br_taken = 1'b1;
    cyc("beq-t IF", 0, IF_DONE);
    cyc("beq-t ID", 1, NONE);
    cyc("beq-t EX", 2, c(0,0,0,0,1,2'd1,0,2'd0,3'd1,0,0,0,0,0,0));
    check("beq-t num_inst", 32'(num_inst), 3);
    txn("BEQ-T");
    br_taken = 1'b0;
    cyc("beq-n IF", 0, IF_DONE);
    cyc("beq-n ID", 1, NONE);
    cyc("beq-n EX", 2, c(0,0,0,0,0,2'd1,0,2'd0,3'd1,0,0,0,0,0,0));
    check("beq-n num_inst", 32'(num_inst), 4);
    txn("BEQ-N");

    // JAL
    instr = 16'hA005;
    cyc("jal IF", 0, IF_DONE);
    cyc("jal ID", 1, c(0,0,0,0,1,2'd2,0,2'd0,3'd0,0,1,0,1,0,0));
    check("jal next state", 32'(state), 0);
    check("jal num_inst", 32'(num_inst), 5);
    txn("JAL");

    // WWD
    instr = 16'hF01C;
    cyc("wwd IF", 0, IF_DONE);
    cyc("wwd ID", 1, c(0,0,0,0,0,2'd0,0,2'd0,3'd0,0,0,0,0,1,0));
    check("wwd num_inst", 32'(num_inst), 6);
    txn("WWD");

    // JPR
    instr = 16'hF019;
    cyc("jpr IF", 0, IF_DONE);
    cyc("jpr ID", 1, c(0,0,0,0,1,2'd3,0,2'd0,3'd0,0,0,0,0,0,0));
    check("jpr num_inst", 32'(num_inst), 7);
    txn("JPR");

    // ADI and LHI
    instr = 16'h4105;
    cyc("adi IF", 0, IF_DONE);
    cyc("adi ID", 1, NONE);
    cyc("adi EX", 2, c(0,0,0,0,0,2'd0,0,2'd2,3'd0,0,0,0,0,0,0));
    cyc("adi WB", 4, c(0,0,0,0,0,2'd0,0,2'd0,3'd0,1,1,0,0,0,0));
    txn("ADI");
    instr = 16'h6100;
    cyc("lhi IF", 0, IF_DONE);
    cyc("lhi ID", 1, NONE);
    cyc("lhi EX", 2, c(0,0,0,0,0,2'd0,0,2'd2,3'd6,0,0,0,0,0,0));
    cyc("lhi WB", 4, c(0,0,0,0,0,2'd0,0,2'd0,3'd0,1,1,0,0,0,0));
    check("lhi num_inst", 32'(num_inst), 9);
    txn("LHI");

    // Undefined func and undefined opcode
    instr = 16'hF03F;
    cyc("ill-f IF", 0, IF_DONE);
    cyc("ill-f ID", 1, c(0,0,0,0,0,2'd0,0,2'd0,3'd0,0,0,0,0,0,1));
    check("ill-f pulse gone", 32'(illegal), 0);
    txn("ILL-F");
    instr = 16'hB000;
    cyc("ill-o IF", 0, IF_DONE);
    cyc("ill-o ID", 1, c(0,0,0,0,0,2'd0,0,2'd0,3'd0,0,0,0,0,0,1));
    check("ill-o num_inst", 32'(num_inst), 11);
    check("ill-o n_num_inst", 32'(n_num_inst), 11);
    txn("ILL-O");

    // SWD interrupted by reset while its write is pending
    instr = 16'h8104;
    cyc("swd IF", 0, IF_DONE);
    cyc("swd ID", 1, NONE);
    cyc("swd EX", 2, c(0,0,0,0,0,2'd0,0,2'd2,3'd0,0,0,0,0,0,0));
    mem_ready = 1'b0;
    #1;
    check("swd MEM ctl", 32'(ctl_w), 32'(c(1,0,1,0,0,2'd0,0,2'd0,3'd0,0,0,0,0,0,0)));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("swd rst mem_write", 32'(mem_write), 0);
    cyc("swd rst", 0, IF_WAIT);
    check("swd rst num_inst", 32'(num_inst), 0);
    txn("SWD-RST");

    // Counter wrap on the 8-bit instance using undefined-instruction NOPs
    instr = 16'hF03F; mem_ready = 1'b1;
    repeat (255) begin
      @(posedge clk);
      @(posedge clk);
    end
    #1;
    check("wrap pre n_num_inst", 32'(n_num_inst), 255);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("wrap n_num_inst", 32'(n_num_inst), 0);
    check("wrap num_inst", 32'(num_inst), 256);
    check("wrap state", 32'(state), 0);
    txn("NOPx256");

    // HLT, then five cycles that must do nothing
    instr = 16'hF01D;
    cyc("hlt IF", 0, IF_DONE);
    cyc("hlt ID", 1, NONE);
    for (int i = 0; i < 5; i++) begin
      check("halt is_halted", 32'(is_halted), 1);
      check("halt num_inst", 32'(num_inst), 257);
      cyc("halt hold", 5, NONE);
    end
    txn("HLT");
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post-halt reset is_halted", 32'(is_halted), 0);
    check("post-halt reset num_inst", 32'(num_inst), 0);
    check("post-halt reset state", 32'(state), 0);
    reset = 1'b0;
    txn("RESET");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
